// File: rtl/door_motor_ctrl.sv
// Garage-door motor controller: push-button start/stop/reverse, obstacle auto-reverse,
// dead time before direction changes, and a travel watchdog that latches a fault.
module door_motor_ctrl #(
  parameter int unsigned TRAVEL_MAX   = 1000,
  parameter int unsigned DEAD_CYCLES  = 4,
  parameter bit          OBST_REVERSE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic activate,
  input  logic up_limit,
  input  logic dn_limit,
  input  logic obstacle,
  input  logic fault_clr,
  output logic motor_up,
  output logic motor_dn,
  output logic fault
);

  localparam int TW = $clog2(TRAVEL_MAX + 1);
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_MAX - 1);
  localparam logic [DW-1:0] DEAD_LAST   = DW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_INIT, S_OPEN, S_CLOSED, S_MOVE_UP, S_MOVE_DN, S_STOPPED, S_DEAD, S_FAULT
  } state_e;

  state_e          state_q, state_d;
  logic            activate_q;
  logic            last_dir_q, last_dir_d;
  logic            dead_up_q, dead_up_d;
  logic [TW-1:0]   travel_q, travel_d;
  logic [DW-1:0]   dead_q, dead_d;
  logic            motor_up_q, motor_dn_q, fault_q;

  logic cmd, in_move, timeout, enter_move;

  assign cmd        = activate & ~activate_q;
  assign in_move    = (state_q == S_MOVE_UP) || (state_q == S_MOVE_DN);
  assign timeout    = in_move && (travel_q == TRAVEL_LAST);
  assign enter_move = ((state_d == S_MOVE_UP) || (state_d == S_MOVE_DN)) && (state_d != state_q);

  always_comb begin
    state_d   = state_q;
    dead_up_d = dead_up_q;
    case (state_q)
      S_INIT: begin
        if (up_limit && dn_limit) state_d = S_FAULT;
        else if (up_limit)        state_d = S_OPEN;
        else if (dn_limit)        state_d = S_CLOSED;
        else                      state_d = S_STOPPED;
      end
      S_OPEN: begin
        if (cmd && !obstacle) state_d = S_MOVE_DN;
      end
      S_CLOSED: begin
        if (cmd) state_d = S_MOVE_UP;
      end
      S_MOVE_DN: begin
        if (dn_limit) state_d = S_CLOSED;
        else if (obstacle) begin
          if (!OBST_REVERSE)         state_d = S_STOPPED;
          else if (DEAD_CYCLES == 0) state_d = S_MOVE_UP;
          else begin
            state_d   = S_DEAD;
            dead_up_d = 1'b1;
          end
        end
        else if (cmd)     state_d = S_STOPPED;
        else if (timeout) state_d = S_FAULT;
      end
      S_MOVE_UP: begin
        if (up_limit)     state_d = S_OPEN;
        else if (cmd)     state_d = S_STOPPED;
        else if (timeout) state_d = S_FAULT;
      end
      S_STOPPED: begin
        // A limit reached by hand takes precedence over a simultaneous press.
        if (up_limit)      state_d = S_OPEN;
        else if (dn_limit) state_d = S_CLOSED;
        else if (cmd) begin
          if (DEAD_CYCLES != 0) begin
            state_d   = S_DEAD;
            dead_up_d = ~last_dir_q;
          end
          else if (!last_dir_q) state_d = S_MOVE_UP;
          else if (obstacle)    state_d = S_STOPPED;
          else                  state_d = S_MOVE_DN;
        end
      end
      S_DEAD: begin
        if (dead_q == DEAD_LAST) begin
          if (dead_up_q)     state_d = S_MOVE_UP;
          else if (obstacle) state_d = S_STOPPED;
          else               state_d = S_MOVE_DN;
        end
      end
      S_FAULT: begin
        if (fault_clr) state_d = S_INIT;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    last_dir_d = last_dir_q;
    if (enter_move)
      last_dir_d = (state_d == S_MOVE_UP);
    else if ((state_q == S_INIT) && (state_d == S_STOPPED))
      last_dir_d = 1'b1;

    travel_d = travel_q;
    if (enter_move)
      travel_d = '0;
    else if (in_move && (travel_q != '1))
      travel_d = travel_q + TW'(1);

    dead_d = dead_q;
    if ((state_d == S_DEAD) && (state_q != S_DEAD))
      dead_d = '0;
    else if ((state_q == S_DEAD) && (dead_q != DEAD_LAST))
      dead_d = dead_q + DW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      activate_q <= 1'b1;
      last_dir_q <= 1'b1;
      dead_up_q  <= 1'b0;
      travel_q   <= '0;
      dead_q     <= '0;
      motor_up_q <= 1'b0;
      motor_dn_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      activate_q <= activate;
      last_dir_q <= last_dir_d;
      dead_up_q  <= dead_up_d;
      travel_q   <= travel_d;
      dead_q     <= dead_d;
      motor_up_q <= (state_d == S_MOVE_UP);
      motor_dn_q <= (state_d == S_MOVE_DN);
      fault_q    <= (state_d == S_FAULT);
    end
  end

  assign motor_up = motor_up_q;
  assign motor_dn = motor_dn_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_door_motor_ctrl.sv
// Bench for door_motor_ctrl: directed vector table, hand-written corner sequences,
// then random stimulus checked against a behavioural door model.
module tb_door_motor_ctrl;

  localparam int TM = 16;
  localparam int DC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic act = 1'b0, ul = 1'b0, dl = 1'b0, obs = 1'b0, clr = 1'b0;
  logic motor_up, motor_dn, fault;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  door_motor_ctrl #(
    .TRAVEL_MAX(TM), .DEAD_CYCLES(DC), .OBST_REVERSE(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .activate(act), .up_limit(ul), .dn_limit(dl),
    .obstacle(obs), .fault_clr(clr), .motor_up(motor_up), .motor_dn(motor_dn),
    .fault(fault)
  );

  always @(negedge clk) begin
    assert (!(motor_up && motor_dn))
    else begin
      n_fail++;
      $display("FAIL excl: motor_up=%b motor_dn=%b, required never both 1", motor_up, motor_dn);
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    string nm;
    logic a, u, d, o, c;
    logic eu, ed, ef;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input string nm, input logic a, u, d, o, c, eu, ed, ef);
    vec_t v;
    v.nm = nm; v.a = a; v.u = u; v.d = d; v.o = o; v.c = c;
    v.eu = eu; v.ed = ed; v.ef = ef;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic a, u, d, o, c);
    act = a; ul = u; dl = d; obs = o; clr = c;
  endtask

  task automatic chk(input string nm, input logic eu, ed, ef);
    n_cmp++;
    if ({motor_up, motor_dn, fault} !== {eu, ed, ef}) begin
      n_fail++;
      $display("FAIL %s: up/dn/fault got %b%b%b required %b%b%b",
               nm, motor_up, motor_dn, fault, eu, ed, ef);
    end
  endtask

  task automatic sc(input string nm, input logic a, u, d, o, c, eu, ed, ef);
    drive(a, u, d, o, c);
    step();
    chk(nm, eu, ed, ef);
  endtask

  // Behavioural model: direction of travel (+1 up, -1 down, 0 still), where the
  // door rests (1 open, 2 closed, 0 mid-way), a countdown for the pause, and
  // the number of cycles spent moving.
  bit m_init, m_fault, m_prev;
  int m_dir, m_wait, m_tgt, m_rest, m_elapsed, m_last;

  task automatic m_reset();
    m_init = 1; m_fault = 0; m_prev = 1;
    m_dir = 0; m_wait = 0; m_tgt = 0; m_rest = 0; m_elapsed = 0; m_last = 1;
  endtask

  task automatic m_start(input int d);
    m_dir = d; m_last = d; m_elapsed = 0; m_rest = 0;
  endtask

  task automatic m_expire(input int t);
    if (t == 1) m_start(1);
    else if (obs) m_rest = 0;
    else m_start(-1);
  endtask

  task automatic m_pause(input int t);
    m_rest = 0;
    if (DC == 0) m_expire(t);
    else begin
      m_wait = DC; m_tgt = t;
    end
  endtask

  task automatic m_step();
    bit cmd;
    cmd = act && !m_prev;
    m_prev = act;
    if (m_fault) begin
      if (clr) begin m_fault = 0; m_init = 1; end
    end else if (m_init) begin
      m_init = 0;
      if (ul && dl) m_fault = 1;
      else if (ul) m_rest = 1;
      else if (dl) m_rest = 2;
      else begin m_rest = 0; m_last = 1; end
    end else if (m_dir == -1) begin
      if (dl) begin m_dir = 0; m_rest = 2; end
      else if (obs) begin m_dir = 0; m_pause(1); end
      else if (cmd) begin m_dir = 0; m_rest = 0; end
      else begin
        m_elapsed++;
        if (m_elapsed == TM) begin m_dir = 0; m_fault = 1; end
      end
    end else if (m_dir == 1) begin
      if (ul) begin m_dir = 0; m_rest = 1; end
      else if (cmd) begin m_dir = 0; m_rest = 0; end
      else begin
        m_elapsed++;
        if (m_elapsed == TM) begin m_dir = 0; m_fault = 1; end
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_expire(m_tgt);
    end else if (m_rest == 1) begin
      if (cmd && !obs) m_start(-1);
    end else if (m_rest == 2) begin
      if (cmd) m_start(1);
    end else begin
      if (ul) m_rest = 1;
      else if (dl) m_rest = 2;
      else if (cmd) m_pause(-m_last);
    end
  endtask

  initial begin
    drive(0, 1, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("reset_state", 0, 0, 0);
    rst_n = 1'b1;

    //   name          act ul dl ob cl  up dn f
    add("init_open",    0, 1, 0, 0, 0,  0, 0, 0);
    add("cmd_down",     1, 1, 0, 0, 0,  0, 1, 0);
    add("dn_run1",      0, 0, 0, 0, 0,  0, 1, 0);
    add("dn_run2",      0, 0, 0, 0, 0,  0, 1, 0);
    add("dn_run3",      0, 0, 0, 0, 0,  0, 1, 0);
    add("dn_limit",     0, 0, 1, 0, 0,  0, 0, 0);
    add("cmd_up",       1, 0, 1, 0, 0,  1, 0, 0);
    add("up_run",       0, 0, 0, 0, 0,  1, 0, 0);
    add("up_limit",     0, 1, 0, 0, 0,  0, 0, 0);
    add("ob_dn1",       1, 1, 0, 0, 0,  0, 1, 0);
    add("ob_dn2",       0, 0, 0, 0, 0,  0, 1, 0);
    add("ob_dn3",       0, 0, 0, 0, 0,  0, 1, 0);
    add("ob_hit",       0, 0, 0, 1, 0,  0, 0, 0);
    add("ob_dead2",     0, 0, 0, 1, 0,  0, 0, 0);
    add("ob_rev_up",    0, 0, 0, 0, 0,  1, 0, 0);
    add("ob_up_run",    0, 0, 0, 0, 0,  1, 0, 0);
    add("ob_open",      0, 1, 0, 0, 0,  0, 0, 0);
    add("open_ob_cmd",  1, 1, 0, 1, 0,  0, 0, 0);
    add("open_held",    1, 1, 0, 0, 0,  0, 0, 0);
    add("open_rel",     0, 1, 0, 0, 0,  0, 0, 0);
    add("open_cmd",     1, 1, 0, 0, 0,  0, 1, 0);
    add("sim_run",      0, 0, 0, 0, 0,  0, 1, 0);
    add("sim_lim_cmd",  1, 0, 1, 0, 0,  0, 0, 0);
    add("sim_consumed", 1, 0, 1, 0, 0,  0, 0, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].a, tbl[i].u, tbl[i].d, tbl[i].o, tbl[i].c);
      step();
      chk(tbl[i].nm, tbl[i].eu, tbl[i].ed, tbl[i].ef);
    end

    // Stop mid-travel, then resume in the opposite direction after the pause.
    sc("sr_rel",  0, 0, 1, 0, 0,  0, 0, 0);
    sc("sr_up1",  1, 0, 1, 0, 0,  1, 0, 0);
    for (int i = 0; i < 3; i++) sc("sr_up", 0, 0, 0, 0, 0,  1, 0, 0);
    sc("sr_stop", 1, 0, 0, 0, 0,  0, 0, 0);
    for (int i = 0; i < 3; i++) sc("sr_held", 1, 0, 0, 0, 0,  0, 0, 0);
    sc("sr_rel2", 0, 0, 0, 0, 0,  0, 0, 0);
    sc("sr_dead1", 1, 0, 0, 0, 0,  0, 0, 0);
    sc("sr_dead2", 1, 0, 0, 0, 0,  0, 0, 0);
    sc("sr_dn",   1, 0, 0, 0, 0,  0, 1, 0);

    // No limit ever arrives: fault exactly TM edges after motor_dn rose.
    for (int i = 1; i < TM; i++) sc("wd_run", 1, 0, 0, 0, 0,  0, 1, 0);
    sc("wd_fault", 1, 0, 0, 0, 0,  0, 0, 1);
    sc("flt_ign0", 0, 0, 0, 0, 0,  0, 0, 1);
    sc("flt_ign1", 1, 0, 0, 0, 0,  0, 0, 1);
    sc("flt_ign2", 0, 0, 0, 0, 0,  0, 0, 1);
    sc("flt_ign3", 1, 1, 0, 1, 0,  0, 0, 1);
    sc("flt_clr",  0, 0, 1, 0, 1,  0, 0, 0);
    sc("flt_closed", 0, 0, 1, 0, 0, 0, 0, 0);
    sc("flt_cmd_up", 1, 0, 1, 0, 0, 1, 0, 0);

    // Reset while moving up, with both limits set during reset.
    drive(0, 1, 1, 0, 0);
    #1 rst_n = 1'b0;
    #1 chk("rst_async_up", 0, 0, 0);
    step();
    rst_n = 1'b1;
    sc("rst_both_fault", 0, 1, 1, 0, 0,  0, 0, 1);

    // Reset mid-way with no limits, then mid MOVE_DN.
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    sc("mm_stop",  0, 0, 0, 0, 0,  0, 0, 0);
    sc("mm_dead1", 1, 0, 0, 0, 0,  0, 0, 0);
    sc("mm_dead2", 1, 0, 0, 0, 0,  0, 0, 0);
    sc("mm_dn",    1, 0, 0, 0, 0,  0, 1, 0);
    sc("mm_dn2",   1, 0, 0, 0, 0,  0, 1, 0);
    #3 rst_n = 1'b0;
    #1 chk("mm_async_drop", 0, 0, 0);
    rst_n = 1'b1;
    sc("mm_init",  1, 0, 0, 0, 0,  0, 0, 0);
    sc("mm_held",  1, 0, 0, 0, 0,  0, 0, 0);
    sc("mm_rel",   0, 0, 0, 0, 0,  0, 0, 0);
    sc("mm_d1",    1, 0, 0, 0, 0,  0, 0, 0);
    sc("mm_d2",    1, 0, 0, 0, 0,  0, 0, 0);
    sc("mm_first_dn", 1, 0, 0, 0, 0, 0, 1, 0);

    // Random traffic against the behavioural model.
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) act = ~act;
      ul  = ($urandom_range(15) == 0);
      dl  = ($urandom_range(15) == 0);
      obs = ($urandom_range(7) == 0);
      clr = ($urandom_range(7) == 0);
      step();
      m_step();
      chk($sformatf("rand%0d", i), m_dir == 1, m_dir == -1, m_fault);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/door_motor_ctrl.md
# door_motor_ctrl

Parametrised garage-door motor controller, the successor to the `motor` block. It turns a single `activate` push-button and two end-of-travel limit switches into exclusive `motor_up`/`motor_dn` drive. Over `motor` it adds stop-on-press mid-travel, obstacle auto-reverse, a programmable dead time before any direction change, and a travel watchdog that latches a fault. It sits between debounced board inputs and the motor driver; all inputs are synchronous to `clk`.

## Interface
- `TRAVEL_MAX`, 1000: max cycles in one move before fault; 1..2^20.
- `DEAD_CYCLES`, 4: cycles with both motor outputs low before reversing direction; 0 disables dead time.
- `OBST_REVERSE`, 1: 1 = obstacle during down travel reverses to up; 0 = obstacle only stops.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `activate`  in  1  push-button level; only its rising edge is a command.
- `up_limit`  in  1  door fully open.
- `dn_limit`  in  1  door fully closed.
- `obstacle`  in  1  beam broken; level-sensitive.
- `fault_clr`  in  1  one-cycle pulse, leaves FAULT.
- `motor_up`  out  1  drive up (registered).
- `motor_dn`  out  1  drive down (registered).
- `fault`  out  1  sticky fault flag (registered).

## Operation
- Command = `activate & ~activate_q`. `activate_q` resets to 1, so a button held through reset does not command.
- `motor_up` and `motor_dn` are never both 1. Each is 1 only in MOVE_UP or MOVE_DN respectively.
- States: INIT, OPEN, CLOSED, MOVE_UP, MOVE_DN, STOPPED, DEAD, FAULT. `last_dir` (1 = up) is a register, reset to 1.
- INIT, first cycle after reset:
  - `up_limit & dn_limit` -> FAULT.
  - `up_limit` -> OPEN.
  - `dn_limit` -> CLOSED.
  - else -> STOPPED with `last_dir`=1, so the next command closes.
- OPEN + command -> MOVE_DN. CLOSED + command -> MOVE_UP. A command while `obstacle`=1 in OPEN is ignored.
- MOVE_DN, priority high to low:
  1. `dn_limit` -> CLOSED.
  2. `obstacle` -> DEAD with target up (OBST_REVERSE=1), or STOPPED (0).
  3. command -> STOPPED.
  4. timeout -> FAULT.
- MOVE_UP, priority high to low: `up_limit` -> OPEN; command -> STOPPED; timeout -> FAULT. `obstacle` is ignored.
- STOPPED + command -> DEAD with target = opposite of `last_dir`.
- DEAD counts DEAD_CYCLES cycles, then enters the target move. DEAD_CYCLES=0 goes straight from STOPPED to the move, and the obstacle path goes straight from MOVE_DN to MOVE_UP.
- Commands in DEAD are ignored. If the target is down and `obstacle`=1 at expiry, go to STOPPED instead.
- Entering MOVE_UP/MOVE_DN sets `last_dir` to 1/0.
- Travel counter: cleared on entry to any MOVE state, increments each MOVE cycle. Width $clog2(TRAVEL_MAX+1). Timeout = counter==TRAVEL_MAX-1 with no limit reached. The counter saturates and never wraps.
- FAULT: motors off, `fault`=1. `fault_clr` -> INIT, and `fault` drops on the same edge. All other inputs are ignored.
- Limit reached while stopped: STOPPED with `up_limit` -> OPEN; with `dn_limit` -> CLOSED (manual move).

## Timing
- Reset values: `motor_up`=0, `motor_dn`=0, `fault`=0, state INIT, counters 0.
- Outputs are registered: an input sampled at edge n is reflected at edge n+1. Latencies:
  - Command -> motor asserted: 1 cycle.
  - Limit -> motor deasserted: 1 cycle.
  - Obstacle -> `motor_dn` low: 1 cycle.
- Reversal: `motor_dn` low for exactly DEAD_CYCLES cycles, then `motor_up` high.
- Timeout: with `motor_dn` first high after edge k, the FAULT state and `fault`=1 appear after edge k+TRAVEL_MAX.
- Asserting `rst_n` mid-move drops both motors asynchronously. After release, INIT resolves from the limits.
- Simultaneous limit and command: the limit wins, and the command is consumed.

## Test plan
- Open-to-close (DEAD_CYCLES=2, TRAVEL_MAX=16), `up_limit`=1:
  - Command -> `motor_dn`=1 next cycle.
  - `dn_limit`=1 after 4 cycles -> `motor_dn`=0 next cycle; state CLOSED.
  - Next command -> `motor_up`=1.
- Obstacle reverse: at cycle 3 of MOVE_DN, `obstacle`=1 -> `motor_dn`=0, both low for exactly 2 cycles, then `motor_up`=1 until `up_limit`.
- Stop/resume:
  - Command at cycle 5 of MOVE_UP -> both low.
  - Second command -> 2 dead cycles, then `motor_dn`=1.
  - Held `activate` gives no further command.
- Watchdog:
  - No limit during MOVE_DN -> `fault`=1 exactly 16 cycles after `motor_dn` rose; motors 0.
  - Commands are ignored while in FAULT.
  - `fault_clr` with `dn_limit`=1 -> CLOSED.
- Reset cases:
  - Reset with both limits 1 -> `fault`=1 after one cycle.
  - Reset mid-MOVE_DN with no limits -> outputs 0 immediately; the first command afterwards drives `motor_dn`.
- Throughout all tests, an assertion checks that `motor_up & motor_dn` is never 1.
